// File: rtl/arthas_fifo_pkg.sv
// Shared types for the FIFO read-side blocks.
// Holds the reader FSM state enum and output buffer depth.
package arthas_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/stream_obuf.sv
// 2-entry output register buffer; entry 0 is always the head.
// Ports: clk, rst (sync, active-low), i_push/i_data, i_pop,
//        o_valid, o_data (head), o_full.
module stream_obuf
  import arthas_fifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_e0;
  logic [WIDTH-1:0] r_e1;
  logic [1:0]       r_cnt;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'(OBUF_DEPTH));
  assign o_data  = r_e0;

  // i_pop is only raised while o_valid is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // shift and refill; count unchanged
          if (r_cnt == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end else begin
            r_e0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a show-ahead FIFO onto a
// valid/ready stream, flagging the final word with m_last.
// Ports: clk, rst (sync, active-low), start, burst_len, busy, done,
//        fifo_re/fifo_empty/fifo_data (FIFO side),
//        m_valid/m_ready/m_data/m_last (stream side).
module fifo_burst_reader
  import arthas_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_re,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  rd_state_t        r_state;
  logic [LEN_W-1:0] r_pop_rem;
  logic [LEN_W-1:0] r_out_rem;
  logic             r_busy;
  logic             r_done;

  logic w_full;
  logic w_valid;
  logic w_hs;
  logic w_re;

  // A full buffer may still accept a pop when the head leaves now.
  assign w_re = (r_state == RUN) & (r_pop_rem != '0) &
                ~fifo_empty & (~w_full | m_ready);
  assign w_hs = w_valid & m_ready;

  assign fifo_re = w_re;
  assign m_valid = w_valid;
  assign m_last  = w_valid & (r_out_rem == LEN_W'(1));
  assign busy    = r_busy;
  assign done    = r_done;

  stream_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_re),
    .i_data  (fifo_data),
    .i_pop   (w_hs),
    .o_valid (w_valid),
    .o_data  (m_data),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pop_rem <= '0;
      r_out_rem <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              r_pop_rem <= burst_len;
              r_out_rem <= burst_len;
              r_busy    <= 1'b1;
              r_state   <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (w_re) r_pop_rem <= r_pop_rem - LEN_W'(1);
          if (w_hs) begin
            r_out_rem <= r_out_rem - LEN_W'(1);
            if (r_out_rem == LEN_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a show-ahead
// FIFO model and a data/last scoreboard on the output stream.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] burst_len;
  logic        busy;
  logic        done;
  logic        fifo_re;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH (16),
    .LEN_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_re    (fifo_re),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  // show-ahead FIFO model
  logic [15:0] mem [0:255];
  int rp = 0;
  int wp = 0;
  assign fifo_empty = (rp == wp);
  assign fifo_data  = mem[rp[7:0]];

  always @(posedge clk) begin
    if (!rst)         rp <= wp;
    else if (fifo_re) rp <= rp + 1;
  end

  // words popped but not yet handed downstream
  int occ = 0;
  always @(posedge clk) begin
    if (!rst) occ <= 0;
    else occ <= occ + int'(fifo_re) - int'(m_valid && m_ready);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q [$];
  logic        mon_en = 1'b0;
  logic        hold_pend = 1'b0;
  logic [16:0] hold_val;

  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else if (mon_en) begin
      if (m_valid && m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got word %h last %b, none expected",
                   m_data, m_last);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            n_fail++;
            $display("FAIL sb_data: got last/data %h exp %h",
                     {m_last, m_data}, e);
          end
        end
      end
      n_checks++;
      if (m_valid !== (occ != 0) || occ > 2) begin
        n_fail++;
        $display("FAIL occupancy: m_valid %b occ %0d exp valid=(occ!=0), occ<=2",
                 m_valid, occ);
      end
      if (occ == 2 && !m_ready) begin
        n_checks++;
        if (fifo_re !== 1'b0) begin
          n_fail++;
          $display("FAIL full_stall: fifo_re %b exp 0", fifo_re);
        end
      end
      if (hold_pend) begin
        n_checks++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== hold_val) begin
          n_fail++;
          $display("FAIL hold_stable: valid %b data %h exp valid 1 data %h",
                   m_valid, {m_last, m_data}, hold_val);
        end
      end
      hold_pend = m_valid && !m_ready;
      hold_val  = {m_last, m_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wp[7:0]] = base + 16'(i);
      wp = wp + 1;
    end
  endtask

  task automatic start_burst(input int len, input bit sb);
    if (sb)
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), mem[8'(rp + i)]});
    start     = 1'b1;
    burst_len = 16'(len);
    tick();
    start     = 1'b0;
    burst_len = 16'hFFFF;
  endtask

  task automatic wait_done(input int bound, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: done 0 after %0d cycles exp 1", nm, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    burst_len = '0;
    m_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, done, fifo_re, m_valid, m_last, m_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %h exp 0",
               {busy, done, fifo_re, m_valid, m_last, m_data});
    end
    tick();
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] ex;
    load(8, 16'h0001);
    start_burst(8, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ex = {(c >= 1 && c <= 8), (c >= 2 && c <= 9),
            (c >= 1 && c <= 9), (c == 10)};
      n_checks++;
      if ({fifo_re, m_valid, busy, done} !== ex) begin
        n_fail++;
        $display("FAIL basic_c%0d: re/valid/busy/done %b exp %b",
                 c, {fifo_re, m_valid, busy, done}, ex);
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0 || !fifo_empty) begin
      n_fail++;
      $display("FAIL basic_end: left %0d empty %b exp 0 1",
               exp_q.size(), fifo_empty);
    end
  endtask

  task automatic test_zero_len();
    int rp0;
    load(10, 16'h0101);
    rp0 = rp;
    start_burst(0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({fifo_re, m_valid, busy, done} !== {3'b000, (c == 1)}) begin
        n_fail++;
        $display("FAIL zero_c%0d: re/valid/busy/done %b exp %b",
                 c, {fifo_re, m_valid, busy, done}, {3'b000, (c == 1)});
      end
      tick();
    end
    n_checks++;
    if (rp != rp0) begin
      n_fail++;
      $display("FAIL zero_pops: popped %0d exp 0", rp - rp0);
    end
  endtask

  task automatic test_partial();
    int rp0 = rp;
    start_burst(4, 1'b1);
    wait_done(20, "partial");
    repeat (2) tick();
    n_checks++;
    if (rp - rp0 != 4 || fifo_empty !== 1'b0 || fifo_data !== 16'h0105) begin
      n_fail++;
      $display("FAIL partial_fifo: pops %0d empty %b head %h exp 4 0 0105",
               rp - rp0, fifo_empty, fifo_data);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL partial_sb: left %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit got = 1'b0;
    m_ready = 1'b1;
    start_burst(6, 1'b1);
    for (int k = 1; k < 60 && !got; k++) begin
      m_ready = (k % 3 == 0);
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
    end
    m_ready = 1'b1;
    n_checks++;
    if (!got || exp_q.size() != 0 || !fifo_empty) begin
      n_fail++;
      $display("FAIL bp_end: done %b left %0d empty %b exp 1 0 1",
               got, exp_q.size(), fifo_empty);
    end
  endtask

  task automatic test_trickle();
    logic [3:0] ex;
    int idx = 0;
    m_ready = 1'b1;
    start_burst(3, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      if (c == 5 || c == 9 || c == 12) begin
        load(1, 16'h0A00 + 16'(idx));
        exp_q.push_back({(idx == 2), 16'h0A00 + 16'(idx)});
        idx++;
      end
      @(negedge clk);
      ex = {(c == 5 || c == 9 || c == 12), (c == 6 || c == 10 || c == 13),
            (c <= 13), (c == 14)};
      n_checks++;
      if ({fifo_re, m_valid, busy, done} !== ex) begin
        n_fail++;
        $display("FAIL trickle_c%0d: re/valid/busy/done %b exp %b",
                 c, {fifo_re, m_valid, busy, done}, ex);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    load(8, 16'h0B01);
    start_burst(8, 1'b1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, done, fifo_re, m_valid, m_last, m_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL midrst_out: got %h exp 0",
               {busy, done, fifo_re, m_valid, m_last, m_data});
    end
    exp_q.delete();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_done: done %b exp 0", done);
      end
      tick();
    end
    load(3, 16'h0C01);
    start_burst(3, 1'b1);
    wait_done(20, "post_rst");
    n_checks++;
    if (exp_q.size() != 0 || !fifo_empty) begin
      n_fail++;
      $display("FAIL post_rst_end: left %0d empty %b exp 0 1",
               exp_q.size(), fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_partial();
    test_backpressure();
    test_trickle();
    test_reset_mid();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

endmodule
